// File: rtl/rv_test_pkg.sv
// Shared definitions for the RISC-V test monitor: monitor states, the halt
// encoding (jal x0,0) and the architectural register count.
package rv_test_pkg;

    localparam int          REG_COUNT  = 32;
    localparam logic [31:0] HALT_INSTR = 32'h0000_006F;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_e;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the core register file: one write port, one combinational
// read port, x0 hardwired to zero; asynchronous active-low clear.
module shadow_regfile
    import rv_test_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == 5'd0) ? '0 : regs[raddr];

endmodule

// File: rtl/rv_test_monitor.sv
// End-of-test monitor: shadows core writebacks until halt or timeout, then
// scans the expected-register table one entry per cycle. Trace: TEST_MONITOR_TRACE_EN.
module rv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 3,
    parameter int MAX_CYCLES = 10000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wb_en,
    input  logic [4:0]                         wb_rd,
    input  logic [XLEN-1:0]                    wb_data,
    input  logic [31:0]                        instr,
    input  logic [5*NUM_CHECKS-1:0]            exp_rd,
    input  logic [XLEN*NUM_CHECKS-1:0]         exp_val,
    output logic                               done,
    output logic                               pass,
    output logic                               fail,
    output logic                               timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0]    mismatch_idx,
    output logic [31:0]                        cycle_count
);

    localparam int            IW       = $clog2(NUM_CHECKS + 1);
    localparam logic [IW-1:0] NO_MISS  = IW'(NUM_CHECKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHECKS - 1);
    localparam logic [31:0]   LIMIT_M1 = 32'(MAX_CYCLES - 1);

    mon_state_e      state;
    logic [IW-1:0]   check_idx;
    logic [4:0]      cur_rd;
    logic [XLEN-1:0] cur_exp;
    logic [XLEN-1:0] cur_val;
    logic            shadow_we;
    logic            halt_seen;
    logic            at_limit;
    logic            entry_mismatch;
    logic            mismatch_seen;

    assign halt_seen      = (instr == HALT_INSTR);
    assign at_limit       = (cycle_count >= LIMIT_M1);
    assign shadow_we      = wb_en && (state == ST_RUN);
    assign entry_mismatch = (cur_val != cur_exp);
    assign mismatch_seen  = (mismatch_idx != NO_MISS);

    always_comb begin
        cur_rd  = exp_rd[4:0];
        cur_exp = exp_val[XLEN-1:0];
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (check_idx == IW'(i)) begin
                cur_rd  = exp_rd[5*i +: 5];
                cur_exp = exp_val[XLEN*i +: XLEN];
            end
        end
    end

    shadow_regfile #(.XLEN(XLEN)) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (shadow_we),
        .waddr (wb_rd),
        .wdata (wb_data),
        .raddr (cur_rd),
        .rdata (cur_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            check_idx    <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            mismatch_idx <= NO_MISS;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    // Halt wins over a timeout landing on the same cycle.
                    if (halt_seen) begin
                        state     <= ST_CHECK;
                        check_idx <= '0;
                    end else if (at_limit) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (entry_mismatch && !mismatch_seen) begin
                        mismatch_idx <= check_idx;
                    end
                    if (check_idx == LAST_IDX) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (mismatch_seen || entry_mismatch) begin
                            fail <= 1'b1;
                        end else begin
                            pass <= 1'b1;
                        end
                    end else begin
                        check_idx <= check_idx + IW'(1);
                    end
                end
                ST_DONE: begin
                end
                default: state <= ST_DONE;
            endcase
        end
    end

`ifdef TEST_MONITOR_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (shadow_we && (wb_rd != 5'd0)) begin
                $display("[%0t] wb x%0d = 0x%0h", $time, wb_rd, wb_data);
            end
            if ((state == ST_CHECK) && entry_mismatch) begin
                $display("[%0t] mismatch entry %0d x%0d expected 0x%0h got 0x%0h",
                         $time, check_idx, cur_rd, cur_exp, cur_val);
            end
            if ((state == ST_CHECK) && (check_idx == LAST_IDX)) begin
                $display("[%0t] test %s", $time,
                         (mismatch_seen || entry_mismatch) ? "FAIL" : "PASS");
            end
            if ((state == ST_RUN) && !halt_seen && at_limit) begin
                $display("[%0t] test TIMEOUT", $time);
            end
        end
    end
`endif

endmodule
